// File: rtl/gate_reduce_unit.sv
// Burst reducer: folds a stream of WIDTH-bit beats with a selectable bitwise gate
// and presents the result, beat count and zero flag over a valid/ready handshake.
module gate_reduce_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;

    logic             accept;
    logic [2:0]       op_eff;
    logic [WIDTH-1:0] reduced;
    logic [WIDTH-1:0] final_data;
    logic [CNT_W-1:0] cnt_nx;

    // 11x decodes to the OR base with inversion, i.e. NOR.
    function automatic logic [WIDTH-1:0] gate_base(input logic [2:0] sel,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (sel)
            3'b000, 3'b011: return a & b;
            3'b010, 3'b101: return a ^ b;
            default:        return a | b;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] gate_finish(input logic [2:0] sel,
                                                     input logic [WIDTH-1:0] x);
        return (sel >= 3'b011) ? ~x : x;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        // First beat of a burst uses the live op; later beats use the latched one.
        op_eff     = (state == IDLE) ? op : op_q;
        reduced    = (state == IDLE) ? in_data : gate_base(op_eff, acc, in_data);
        final_data = gate_finish(op_eff, reduced);
        cnt_nx     = sat_inc((state == IDLE) ? '0 : cnt);
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE, ACC: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_nx = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            op_q      <= 3'b000;
            out_data  <= '0;
            out_count <= '0;
            out_zero  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                acc <= reduced;
                cnt <= cnt_nx;
                if (state == IDLE) begin
                    op_q <= op;
                end
                if (in_last) begin
                    out_data  <= final_data;
                    out_count <= cnt_nx;
                    out_zero  <= (final_data == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_reduce_unit.sv
// Self-checking bench for gate_reduce_unit: vector table, hand-written corner
// sequences and random bursts against a queue-based reference model.
module tb_gate_reduce_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       op = 3'b000;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    gate_reduce_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       op;
        int               n;
        logic [3:0][7:0]  d;
        bit               gap;
        logic [7:0]       exp_data;
        int               exp_count;
        bit               exp_zero;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: fold the whole burst with the gate named by op, then invert for the N-forms.
    function automatic logic [7:0] model_data(input logic [2:0] o, input logic [7:0] q[$]);
        logic [7:0] r;
        r = q[0];
        for (int i = 1; i < q.size(); i++) begin
            if (o == 3'd0 || o == 3'd3)      r = r & q[i];
            else if (o == 3'd2 || o == 3'd5) r = r ^ q[i];
            else                             r = r | q[i];
        end
        if (o >= 3'd3) r = ~r;
        return r;
    endfunction

    function automatic int model_count(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    // Later beats carry a scrambled op to show it is ignored mid-burst.
    task automatic send_burst(input logic [2:0] o, input logic [7:0] q[$], input int gap_mask);
        for (int i = 0; i < q.size(); i++) begin
            if (gap_mask[i % 32]) begin
                in_valid = 1'b0;
                in_last  = 1'b1;
                in_data  = 8'h00;
                step();
            end
            op       = (i == 0) ? o : ~o;
            in_valid = 1'b1;
            in_data  = q[i];
            in_last  = (i == q.size() - 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [7:0] d, input int c, input bit z);
        check({name, ".valid"}, 32'(out_valid), 32'd1);
        check({name, ".data"},  32'(out_data),  32'(d));
        check({name, ".count"}, 32'(out_count), 32'(c));
        check({name, ".zero"},  32'(out_zero),  32'(z));
        check({name, ".ready"}, 32'(in_ready),  32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, ".drop"},  32'(out_valid), 32'd0);
        check({name, ".hold"},  32'(out_data),  32'(d));
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] held;
        logic [2:0] ro;
        int         n;
        int         gm;

        vecs[0] = '{3'b100, 2, {8'h00, 8'h00, 8'h30, 8'h0F}, 1'b0, 8'hC0, 2, 1'b0};
        vecs[1] = '{3'b010, 3, {8'h00, 8'hAA, 8'h0F, 8'hFF}, 1'b1, 8'h5A, 3, 1'b0};
        vecs[2] = '{3'b101, 3, {8'h00, 8'hAA, 8'h0F, 8'hFF}, 1'b1, 8'hA5, 3, 1'b0};
        vecs[3] = '{3'b011, 1, {8'h00, 8'h00, 8'h00, 8'hFF}, 1'b0, 8'h00, 1, 1'b1};
        vecs[4] = '{3'b000, 2, {8'h00, 8'h00, 8'h3C, 8'hF0}, 1'b0, 8'h30, 2, 1'b0};
        vecs[5] = '{3'b110, 2, {8'h00, 8'h00, 8'h02, 8'h01}, 1'b0, 8'hFC, 2, 1'b0};
        vecs[6] = '{3'b001, 4, {8'h08, 8'h04, 8'h02, 8'h01}, 1'b0, 8'h0F, 4, 1'b0};

        // Reset with a would-be beat present the whole time.
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
        step();
        step();
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data",  32'(out_data),  32'd0);
        check("rst.count", 32'(out_count), 32'd0);
        check("rst.zero",  32'(out_zero),  32'd0);
        check("rst.ready", 32'(in_ready),  32'd1);
        step();
        check("rst.noacc", 32'(out_valid), 32'd0);

        foreach (vecs[k]) begin
            q = {};
            for (int j = 0; j < vecs[k].n; j++) q.push_back(vecs[k].d[j]);
            send_burst(vecs[k].op, q, vecs[k].gap ? 2 : 0);
            expect_result($sformatf("vec%0d", k), vecs[k].exp_data, vecs[k].exp_count, vecs[k].exp_zero);
        end

        // Backpressure: result held, beats refused, outputs stable.
        q = {8'h0F, 8'h30};
        send_burst(3'b100, q, 0);
        held = out_data;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = 8'h12; in_last = 1'b1; op = 3'b001;
            step();
            check("bp.valid", 32'(out_valid), 32'd1);
            check("bp.ready", 32'(in_ready),  32'd0);
            check("bp.data",  32'(out_data),  32'(held));
            check("bp.count", 32'(out_count), 32'd2);
        end
        in_valid = 1'b0; in_last = 1'b0;
        expect_result("bp.res", 8'hC0, 2, 1'b0);
        q = {8'hF0, 8'h3C};
        send_burst(3'b000, q, 0);
        expect_result("bp.next", 8'h30, 2, 1'b0);

        // Saturating count over a 20-beat OR burst.
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(8'(1 << (i % 8)));
        send_burst(3'b001, q, 0);
        expect_result("sat", 8'hFF, CMAX, 1'b0);

        // Reset three beats into a burst.
        q = {8'h11, 8'h22, 8'h44};
        for (int i = 0; i < 3; i++) begin
            op = 3'b001; in_valid = 1'b1; in_data = q[i]; in_last = 1'b0;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst.valid", 32'(out_valid), 32'd0);
        check("mrst.data",  32'(out_data),  32'd0);
        check("mrst.count", 32'(out_count), 32'd0);
        check("mrst.ready", 32'(in_ready),  32'd1);
        q = {8'h81};
        send_burst(3'b001, q, 0);
        expect_result("mrst.fresh", 8'h81, 1, 1'b0);

        // Random bursts against the model.
        for (int t = 0; t < 40; t++) begin
            ro = 3'($urandom_range(0, 7));
            n  = $urandom_range(1, 20);
            gm = ($urandom_range(0, 3) == 0) ? int'($urandom) : 0;
            q  = {};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) q.push_back(8'hFF ^ (8'h1 << $urandom_range(0, 7)));
                else                           q.push_back(8'($urandom));
            end
            send_burst(ro, q, gm);
            expect_result($sformatf("rnd%0d", t), model_data(ro, q), model_count(n),
                          model_data(ro, q) == 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_reduce_unit.md
Name: gate_reduce_unit

Overview:
- Parametrised, registered successor to the two-input combinational gate blocks.
- Reduces a burst of WIDTH-bit operands, one per cycle, with a selectable bitwise gate: AND, OR, XOR, NAND, NOR or XNOR.
- Operands and result use valid/ready handshakes, so the unit sits between a stimulus source (switches/UART/LFSR) and a display or checker.

Parameters:
WIDTH, 8, operand and result bit width (>=1)
CNT_W, 4, width of the beat counter; count saturates at 2^CNT_W-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
op  input  3  gate select: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 11x treated as NOR
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat
in_data  input  WIDTH  operand
in_last  input  1  marks final beat of burst
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  reduced result
out_count  output  CNT_W  number of beats in burst (saturating)
out_zero  output  1  out_data == 0

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst, sampled on the rising edge; it overrides all other inputs.
- Reset values: state IDLE, out_valid 0, out_data 0, out_count 0, out_zero 0, internal accumulator 0, latched op 000. in_ready is 1 from the first cycle after reset.
- Beat accepted when in_valid & in_ready on a rising edge.
- States:
  - IDLE: in_ready=1, out_valid=0. On accept: latch op, acc<=in_data, cnt<=1. in_last=1 -> FINISH; else -> ACC.
  - ACC: in_ready=1. On accept: acc<=acc BASE in_data, cnt<=cnt+1 (saturating). in_last=1 -> FINISH. No accept -> stay; acc and cnt hold.
  - HOLD: in_ready=0, out_valid=1, all outputs stable. out_ready=1 -> IDLE next cycle (out_valid drops to 0). Otherwise stay.
- FINISH is a transition action, not a state. On the edge accepting the last beat, register the final values and enter HOLD:
  - out_data <= f(acc BASE in_data) when ACC; f(in_data) when IDLE.
  - out_count <= cnt+1 saturating.
  - out_zero computed from the new out_data.
- BASE/f mapping:
  - AND/NAND use AND; OR/NOR use OR; XOR/XNOR use XOR.
  - f inverts all bits for NAND, NOR, XNOR; identity otherwise.
- Latency: out_valid asserts the cycle after the last beat is accepted. Burst of N beats -> first result N cycles after first accept, assuming no gaps.
- Throughput: at least one idle cycle between bursts (HOLD->IDLE). A new burst cannot be accepted in the same cycle as the result handshake.
- The op port is sampled only on the first beat; changes mid-burst are ignored.
- Saturation: cnt stops at 2^CNT_W-1; reduction continues correctly past saturation.
- in_last with in_valid low: ignored.
- Reset mid-burst or during HOLD: partial acc discarded, pending result dropped, all outputs take reset values.
- out_data, out_count, out_zero change only on entry to HOLD or on reset. In IDLE and ACC they hold the last result.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0x00, out_count=0, out_zero=0; in_ready=1 the cycle after rst deasserts; no beat accepted during rst.
2. NOR two beats (WIDTH=8): op=100, 0x0F then 0x30 with in_last -> next cycle out_valid=1, out_data=0xC0, out_count=2, out_zero=0; out_ready=1 -> out_valid=0 next cycle.
3. XOR three beats with a one-cycle in_valid gap: 0xFF, gap, 0x0F, 0xAA(last) -> out_data=0x5A, out_count=3. Same burst with op=101 -> 0xA5.
4. Single-beat NAND: op=011, 0xFF with in_last -> out_data=0x00, out_zero=1, out_count=1. Flip op to 000 on the same beat -> no effect on the registered op afterward.
5. Backpressure: hold out_ready=0 for 5 cycles after result -> in_ready=0, in_valid beats refused, outputs stable. Raise out_ready -> IDLE; next burst with op=000, 0xF0, 0x3C(last) -> 0x30.
6. Saturation and reset: CNT_W=4, OR burst of 20 beats, each a one-hot rotating value -> out_count=15, out_data=0xFF. Then start a burst, assert rst after 3 beats -> outputs at reset values. A fresh 1-beat OR of 0x81 -> 0x81, count 1.
